// File: rtl/dds_reg_writer.sv
// dds_reg_writer: drives a DDS parallel programming port with a timed register burst,
// then optionally raises UEN for a fixed window and pulses DONE when the transaction ends.
module dds_reg_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int WR_LOW_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int UEN_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  start_addr,
  input  logic [3:0]  nbytes,
  input  logic [63:0] data_in,
  input  logic        upd_en,
  output logic [5:0]  dds_a,
  output logic [7:0]  dds_d,
  output logic        dds_wrb,
  output logic        uen,
  output logic        busy,
  output logic        done
);
  localparam int M1 = SETUP_CYC > WR_LOW_CYC ? SETUP_CYC : WR_LOW_CYC;
  localparam int M2 = HOLD_CYC > UEN_CYC ? HOLD_CYC : UEN_CYC;
  localparam int MAXC = M1 > M2 ? M1 : M2;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, UPD, FIN} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [3:0] rem, nc;
  logic [5:0] addr_q;
  logic [63:0] data_q;
  logic upd_q, go, last, adv;
  assign nc = nbytes > 4'd8 ? 4'd8 : nbytes;
  assign last = cnt == '0;
  // go marks the one-clock latch cycle after an accepted start; both it and the end of
  // a byte's hold phase decide what comes next (another byte, the update window, or FIN)
  assign adv = (st == IDLE && go) || (st == HOLD && last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      rem <= '0;
      addr_q <= '0;
      data_q <= '0;
      upd_q <= 1'b0;
      go <= 1'b0;
      dds_a <= '0;
      dds_d <= '0;
      dds_wrb <= 1'b1;
      uen <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (adv) begin
      go <= 1'b0;
      busy <= 1'b1;
      if (rem != '0) begin
        st <= SETUP;
        cnt <= CW'(SETUP_CYC - 1);
        rem <= rem - 4'd1;
        dds_a <= addr_q;
        addr_q <= addr_q + 6'd1;
        dds_d <= data_q[63:56];
        data_q <= {data_q[55:0], 8'h00};
      end else if (upd_q) begin
        st <= UPD;
        cnt <= CW'(UEN_CYC - 1);
        uen <= 1'b1;
      end else begin
        st <= FIN;
        done <= 1'b1;
      end
    end else begin
      case (st)
        IDLE: if (start) begin
          go <= 1'b1;
          addr_q <= start_addr;
          data_q <= data_in << {4'd8 - nc, 3'b000};
          rem <= nc;
          upd_q <= upd_en;
        end
        SETUP: begin
          st <= last ? STROBE : SETUP;
          cnt <= last ? CW'(WR_LOW_CYC - 1) : cnt - CW'(1);
          dds_wrb <= !last;
        end
        STROBE: begin
          st <= last ? HOLD : STROBE;
          cnt <= last ? CW'(HOLD_CYC - 1) : cnt - CW'(1);
          dds_wrb <= last;
        end
        HOLD: cnt <= cnt - CW'(1);
        UPD: begin
          st <= last ? FIN : UPD;
          cnt <= cnt - CW'(1);
          uen <= !last;
          done <= last;
        end
        FIN: begin
          st <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_reg_writer.sv
// tb_dds_reg_writer: random and directed bursts checked cycle by cycle against a
// trace model built directly from the port timing rules.
module tb_dds_reg_writer;
  localparam int SC = 2, WL = 2, HC = 1, UC = 4;
  logic clk = 0, rst_n = 0, start = 0, upd_en = 0;
  logic [5:0] start_addr = 0;
  logic [3:0] nbytes = 0;
  logic [63:0] data_in = 0;
  logic [5:0] dds_a;
  logic [7:0] dds_d;
  logic dds_wrb, uen, busy, done;
  logic [17:0] o;
  logic [5:0] la = 0;
  logic [7:0] ld = 0;
  int total = 0, bad = 0;
  dds_reg_writer #(.SETUP_CYC(SC), .WR_LOW_CYC(WL), .HOLD_CYC(HC), .UEN_CYC(UC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .nbytes(nbytes),
    .data_in(data_in), .upd_en(upd_en), .dds_a(dds_a), .dds_d(dds_d), .dds_wrb(dds_wrb),
    .uen(uen), .busy(busy), .done(done)
  );
  assign o = {dds_a, dds_d, dds_wrb, uen, busy, done};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic scramble();
    start_addr = 6'($urandom);
    nbytes = 4'($urandom);
    data_in = {$urandom, $urandom};
    upd_en = 1'($urandom);
  endtask
  // Expected trace per clock from E1: {a, d, wrb, uen, busy, done}
  task automatic txn(input logic [5:0] addr, input logic [3:0] nb, input logic [63:0] data,
                     input logic upd, input bit hold, input int abort_at, input string name);
    logic [17:0] q[$];
    logic [17:0] go_exp;
    logic [5:0] a;
    logic [7:0] d;
    int n;
    n = nb > 8 ? 8 : int'(nb);
    go_exp = {la, ld, 4'b1000};
    for (int k = 0; k < n; k++) begin
      a = addr + 6'(k);
      d = 8'((data >> (8 * (n - 1 - k))) & 64'hff);
      repeat (SC) q.push_back({a, d, 4'b1010});
      repeat (WL) q.push_back({a, d, 4'b0010});
      repeat (HC) q.push_back({a, d, 4'b1010});
      la = a;
      ld = d;
    end
    if (upd) repeat (UC) q.push_back({la, ld, 4'b1110});
    q.push_back({la, ld, 4'b1011});
    q.push_back({la, ld, 4'b1000});
    start_addr = addr;
    nbytes = nb;
    data_in = data;
    upd_en = upd;
    start = 1;
    step();
    chk({name, ".latch"}, 64'(o), 64'(go_exp));
    scramble();
    start = hold;
    foreach (q[i]) begin
      step();
      chk($sformatf("%s[%0d]", name, i), 64'(o), 64'(q[i]));
      if (q[i][0]) start = 0;
      if (i == abort_at) begin
        #2 rst_n = 0;
        start = 0;
        la = 0;
        ld = 0;
        #1 chk({name, ".abort"}, 64'(o), 64'({14'd0, 4'b1000}));
        repeat (3) begin
          step();
          chk({name, ".in_rst"}, 64'(o), 64'({14'd0, 4'b1000}));
        end
        rst_n = 1;
        step();
        chk({name, ".post_rst"}, 64'(o), 64'({14'd0, 4'b1000}));
        return;
      end
    end
  endtask
  initial begin
    step();
    step();
    chk("reset", 64'(o), 64'({14'd0, 4'b1000}));
    rst_n = 1;
    step();
    chk("idle", 64'(o), 64'({14'd0, 4'b1000}));
    txn(6'h04, 4'd6, 64'h123456789ABC, 1'b1, 1'b0, -1, "ftw");
    txn(6'h3E, 4'd10, 64'h0102030405060708, 1'b0, 1'b0, -1, "wrap");
    txn(6'h10, 4'd0, 64'hDEAD, 1'b1, 1'b0, -1, "upd_only");
    txn(6'h20, 4'd0, 64'h0, 1'b0, 1'b0, -1, "empty");
    txn(6'h04, 4'd6, 64'h123456789ABC, 1'b1, 1'b1, -1, "held");
    txn(6'h04, 4'd6, 64'h123456789ABC, 1'b1, 1'b0, -1, "after_held");
    txn(6'h04, 4'd6, 64'h123456789ABC, 1'b1, 1'b0, 12, "abort");
    txn(6'h04, 4'd6, 64'h123456789ABC, 1'b1, 1'b0, -1, "restart");
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("gap", 64'(o), 64'({la, ld, 4'b1000}));
      end
      txn(6'($urandom), 4'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom), -1,
          $sformatf("rnd%0d", t));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
